// File: rtl/apb_ram_completer_if.sv
// APB bus bundle between the core's initiator and the RAM completer.
// Read data is right-justified; pslverr is meaningful only alongside pready.
interface apb_ram_completer_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [1:0]  psize;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, psize, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, psize, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_ram_completer.sv
// APB completer backed by a word-organised RAM with byte/half/word lanes and
// a programmable number of wait states; errors on range or alignment faults.
module apb_ram_completer #(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  apb_ram_completer_if.slave bus
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_SETUP  = 2'd1;
  localparam logic [1:0]  S_ACCESS = 2'd2;
  localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
  localparam logic [3:0]  WS       = 4'(WAIT_STATES);

  logic [31:0]   r_mem [DEPTH];
  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_write;
  logic [31:0]   r_addr;
  logic [1:0]    r_size;
  logic [31:0]   r_wdata;
  logic [31:0]   r_prdata;
  logic          r_pready;
  logic          r_pslverr;

  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_range;
  logic          w_err;
  logic          w_fire;

  function automatic logic [31:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 32'h0000_00FF;
      2'd1:    size_mask = 32'h0000_FFFF;
      default: size_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  // Merge right-justified write data into the addressed lanes only.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] wd,
                                              input logic [1:0] o, input logic [1:0] sz);
    logic [4:0]  sh;
    logic [31:0] m;
    sh = {o, 3'b000};
    m  = size_mask(sz) << sh;
    merge_lanes = (old_w & ~m) | ((wd << sh) & m);
  endfunction

  function automatic logic [31:0] align_read(input logic [31:0] word, input logic [1:0] o,
                                             input logic [1:0] sz);
    logic [4:0] sh;
    sh = {o, 3'b000};
    align_read = (word >> sh) & size_mask(sz);
  endfunction

  assign w_off   = r_addr - BASE_ADDR;
  assign w_idx   = AW'(w_off >> 2);
  assign w_range = ({1'b0, r_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, r_addr} < LIMIT);
  assign w_err   = !w_range || (r_size == 2'd3) ||
                   ((r_size == 2'd1) && r_addr[0]) ||
                   ((r_size == 2'd2) && (r_addr[1:0] != 2'b00));

  // Completion is scheduled one edge ahead so pready and read data are registered.
  assign w_fire  = bus.psel && bus.penable &&
                   (((r_state == S_SETUP) && (r_cnt == 4'd0)) ||
                    ((r_state == S_ACCESS) && !r_pready && (r_cnt == 4'd1)));

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.psel && !bus.penable) begin
      r_write <= bus.pwrite;
      r_addr  <= bus.paddr;
      r_size  <= bus.psize;
      r_wdata <= bus.pwdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_prdata  <= 32'd0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.psel && !bus.penable) begin
            r_cnt   <= WS;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (bus.psel && bus.penable) r_state <= S_ACCESS;
          else                         r_state <= S_IDLE;
        end
        S_ACCESS: begin
          if (r_pready || !bus.psel) r_state <= S_IDLE;
          else                       r_cnt   <= r_cnt - 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_fire) begin
        r_pready  <= 1'b1;
        r_pslverr <= w_err;
        if (w_err)         r_prdata <= 32'd0;
        else if (!r_write) r_prdata <= align_read(r_mem[w_idx], r_addr[1:0], r_size);
      end
    end
  end

  // Writes commit on the completion cycle; reset in that cycle drops them.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_ACCESS && r_pready && r_write && !w_err)
      r_mem[w_idx] <= merge_lanes(r_mem[w_idx], r_wdata, r_addr[1:0], r_size);
  end

  assign bus.prdata  = r_prdata;
  assign bus.pready  = r_pready;
  assign bus.pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_ram_completer.sv
// Scoreboard bench for apb_ram_completer: a zero-wait and a three-wait instance
// share one APB driver; a monitor checks every pready against queued expectations.
module tb_apb_ram_completer;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_sel;
  logic        s_psel, s_penable, s_pwrite;
  logic [31:0] s_paddr, s_pwdata;
  logic [1:0]  s_psize;
  logic [31:0] last_rd [2];
  exp_t        q [$];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  logic        w_pready, w_pslverr;
  logic [31:0] w_prdata;

  apb_ram_completer_if b0 ();
  apb_ram_completer_if b3 ();

  assign b0.psel    = s_psel & ~s_sel;
  assign b3.psel    = s_psel & s_sel;
  assign b0.penable = s_penable;
  assign b3.penable = s_penable;
  assign b0.pwrite  = s_pwrite;
  assign b3.pwrite  = s_pwrite;
  assign b0.paddr   = s_paddr;
  assign b3.paddr   = s_paddr;
  assign b0.psize   = s_psize;
  assign b3.psize   = s_psize;
  assign b0.pwdata  = s_pwdata;
  assign b3.pwdata  = s_pwdata;

  assign w_pready  = s_sel ? b3.pready  : b0.pready;
  assign w_pslverr = s_sel ? b3.pslverr : b0.pslverr;
  assign w_prdata  = s_sel ? b3.prdata  : b0.prdata;

  apb_ram_completer #(.DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0));
  apb_ram_completer #(.DEPTH(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut3 (
    .clk(clk), .rst(rst), .bus(b3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pready must match the oldest outstanding expectation.
  logic prev_rdy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_rdy = 1'b0;
    end else begin
      if (prev_rdy) chk("pready_width", {31'd0, w_pready}, 32'd0);
      if (w_pready && !prev_rdy) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_pready: got pready=1 expected none (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("prdata", w_prdata, e.rd);
          chk("pslverr", {31'd0, w_pslverr}, {31'd0, e.err});
          chk("latency", 32'(cyc - e.cyc), 32'(e.lat));
        end
      end
      prev_rdy = w_pready;
    end
  end

  task automatic xfer(input logic w, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] d, input logic [31:0] erd, input logic eerr);
    exp_t e;
    bit   done;
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = w;
    s_paddr = a; s_psize = sz; s_pwdata = d;
    e.rd = erd; e.err = eerr; e.cyc = cyc; e.lat = s_sel ? 5 : 2;
    q.push_back(e);
    last_rd[s_sel] = erd;
    @(posedge clk); #1;
    s_penable = 1'b1;
    s_pwrite = ~w; s_paddr = ~a; s_psize = ~sz; s_pwdata = ~d;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = w_pready;
    end
    @(posedge clk); #1;
    s_psel = 1'b0; s_penable = 1'b0;
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL timeout: got no pready expected one within 40 cycles (addr %h)", a);
      q.delete();
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                    input logic err);
    xfer(1'b1, a, sz, d, err ? 32'd0 : last_rd[s_sel], err);
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] exp,
                    input logic err);
    xfer(1'b0, a, sz, 32'h0, err ? 32'd0 : exp, err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_sel = 1'b0;
    s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
    s_paddr = 32'h0; s_psize = 2'd0; s_pwdata = 32'h0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pready0", {31'd0, b0.pready}, 32'd0);
    chk("rst_pslverr0", {31'd0, b0.pslverr}, 32'd0);
    chk("rst_prdata0", b0.prdata, 32'd0);
    chk("rst_pready3", {31'd0, b3.pready}, 32'd0);
    chk("rst_pslverr3", {31'd0, b3.pslverr}, 32'd0);
    chk("rst_prdata3", b3.prdata, 32'd0);
    @(posedge clk); #1;

    // Zero wait states: word, then byte/half lanes
    s_sel = 1'b0;
    wr(32'h10, 2'd2, 32'hDEADBEEF, 1'b0);
    rd(32'h10, 2'd2, 32'hDEADBEEF, 1'b0);
    wr(32'h11, 2'd0, 32'h555555AA, 1'b0);
    wr(32'h12, 2'd1, 32'h99991234, 1'b0);
    rd(32'h10, 2'd2, 32'h1234AAEF, 1'b0);
    rd(32'h11, 2'd0, 32'h000000AA, 1'b0);
    rd(32'h12, 2'd1, 32'h00001234, 1'b0);
    rd(32'h13, 2'd0, 32'h00000012, 1'b0);

    // Error responses leave RAM intact
    wr(32'h0,    2'd2, 32'h11111111, 1'b0);
    wr(32'h13,   2'd2, 32'hFFFFFFFF, 1'b1);
    rd(32'h01,   2'd1, 32'h0,        1'b1);
    rd(32'h10,   2'd2, 32'h1234AAEF, 1'b0);
    wr(32'h1000, 2'd2, 32'hFFFFFFFF, 1'b1);
    rd(32'h1000, 2'd2, 32'h0,        1'b1);
    wr(32'h10,   2'd3, 32'h00000000, 1'b1);
    rd(32'h0,    2'd2, 32'h11111111, 1'b0);
    rd(32'h10,   2'd2, 32'h1234AAEF, 1'b0);

    // Access phase without a setup is ignored
    s_psel = 1'b1; s_penable = 1'b1; s_pwrite = 1'b1;
    s_paddr = 32'h10; s_psize = 2'd2; s_pwdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 s_psel = 1'b0; s_penable = 1'b0;
    @(posedge clk); #1;
    rd(32'h10, 2'd2, 32'h1234AAEF, 1'b0);

    // Three wait states, back-to-back
    s_sel = 1'b1;
    wr(32'h20, 2'd2, 32'hCAFEF00D, 1'b0);
    rd(32'h20, 2'd2, 32'hCAFEF00D, 1'b0);
    rd(32'h22, 2'd1, 32'h0000CAFE, 1'b0);
    wr(32'h23, 2'd1, 32'h00001234, 1'b1);

    // Abort during wait states
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b1;
    s_paddr = 32'h20; s_psize = 2'd2; s_pwdata = 32'h0;
    @(posedge clk); #1 s_penable = 1'b1;
    repeat (2) @(posedge clk);
    #1 s_psel = 1'b0; s_penable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd(32'h20, 2'd2, 32'hCAFEF00D, 1'b0);

    // Reset while a write is in its wait states
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b1;
    s_paddr = 32'h20; s_psize = 2'd2; s_pwdata = 32'h0BADC0DE;
    @(posedge clk); #1 s_penable = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    @(negedge clk);
    chk("midrst_pready", {31'd0, b3.pready}, 32'd0);
    chk("midrst_pslverr", {31'd0, b3.pslverr}, 32'd0);
    chk("midrst_prdata", b3.prdata, 32'd0);
    @(posedge clk); #1;
    rd(32'h20, 2'd2, 32'hCAFEF00D, 1'b0);
    wr(32'h24, 2'd2, 32'h01020304, 1'b0);
    rd(32'h25, 2'd0, 32'h00000003, 1'b0);

    repeat (5) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/apb_ram_completer.md
Name: apb_ram_completer

Overview:
- APB completer (responder) that answers the core's APB initiator transfers.
- Backed by a word-organised synchronous RAM with byte/half/word access and a parameterised wait-state count.
- Read data is returned right-justified, so the core's load extension operates on prdata[7:0] and prdata[15:0] directly.
- Reports pslverr for out-of-range or misaligned accesses; sits on the system APB as the instruction/data memory completer.

Parameters:
- DEPTH, 1024, number of 32-bit words; byte address range 0 .. 4*DEPTH-1.
- WAIT_STATES, 0, access-phase cycles with pready low before completion (0..15).
- BASE_ADDR, 32'h0, byte address of word 0; paddr below BASE or at/after BASE+4*DEPTH is out of range.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- psel  in  1  completer selected.
- penable  in  1  access phase.
- pwrite  in  1  1=write, 0=read; sampled in setup.
- paddr  in  32  byte address; sampled in setup.
- psize  in  2  0=byte, 1=half, 2=word, 3=reserved; sampled in setup.
- pwdata  in  32  right-justified write data; sampled in setup.
- prdata  out  32  right-justified read data, valid while pready=1 on a read.
- pready  out  1  transfer completes this cycle.
- pslverr  out  1  error response, valid only while pready=1.

Behaviour:
- Reset: state IDLE, wait counter 0, prdata=0, pready=0, pslverr=0. RAM contents are not cleared.
- FSM state IDLE:
  - psel=1 and penable=0 (setup) -> capture pwrite/paddr/psize/pwdata, load counter with WAIT_STATES, go SETUP.
  - psel=1 and penable=1 with no prior setup -> ignore and stay IDLE; pready=0.
- FSM state SETUP (one cycle, the initiator's setup-to-access edge):
  - psel=1 and penable=1 -> go ACCESS.
  - psel=0 -> go IDLE with no side effects.
- FSM state ACCESS:
  - counter>0: pready=0, counter decrements.
  - counter==0: pready=1 for exactly one cycle, then go IDLE.
  - A new setup in the cycle following completion is accepted normally, giving back-to-back transfers every 2+WAIT_STATES cycles.
  - psel dropping while pready=0 -> abort to IDLE; no write, no response.
- Error check, computed from captured fields:
  - err = out-of-range, or psize=3, or (psize=1 and addr[0]), or (psize=2 and addr[1:0]!=0).
  - On completion with err: pslverr=1, prdata=0, RAM unmodified.
- Write (completion cycle, no err):
  - Word index = (addr-BASE_ADDR)>>2; byte offset o = addr[1:0].
  - byte: RAM byte lane o = pwdata[7:0].
  - half: lanes o and o+1 = pwdata[15:0].
  - word: all lanes = pwdata.
  - Unaddressed lanes are preserved.
- Read:
  - RAM read issues once the counter reaches 0 (last cycle before or at completion, as the implementation's RAM latency requires). Data must be registered so it is presented with pready.
  - prdata = word >> (8*o), upper bits zero-filled beyond psize. Byte: {24'b0,byte}; half: {16'b0,half}. Sign extension is the core's job.
- Outputs pready/pslverr/prdata are registered; prdata holds its value after completion until the next read completion or reset.
- Reset mid-transfer: FSM returns to IDLE next edge, pending write is dropped, pready=0.
- Inputs changing during ACCESS have no effect; the captured setup values are used.

Test Plan:
1. WAIT_STATES=0: write word 32'hDEADBEEF at 0x10, then read word 0x10 -> each transfer pready=1 on the 2nd cycle after setup; read returns prdata=32'hDEADBEEF, pslverr=0.
2. Byte/half lanes: write byte 0xAA at 0x11, then half 0x1234 at 0x12 over word 0x10 holding DEADBEEF -> word reads 32'h1234AAEF; byte read at 0x11 gives 32'h000000AA; half read at 0x12 gives 32'h00001234.
3. WAIT_STATES=3: read -> pready low for 3 access cycles, high on the 4th, exactly one cycle; back-to-back transfer accepted immediately after.
4. Errors: word write to 0x13, half read at 0x01, access at BASE+4*DEPTH, psize=3 -> pslverr=1 with pready, prdata=0, subsequent reads show RAM unchanged.
5. Abort/protocol: psel deasserted during wait states of a write, and penable=1 without setup -> no pready, no RAM change, FSM back in IDLE.
6. rst asserted during ACCESS of a write -> next cycle pready=0, pslverr=0, prdata=0, target word unchanged; normal transfer succeeds afterward.
